// File: rtl/avalon_slave_regbank.sv
// Avalon-MM responder register bank: ID/STATUS/CTRL/WCOUNT plus general registers,
// fixed-latency read pipeline and a registered level interrupt.
module avalon_slave_regbank #(
    parameter int ADDRESS_SIZE   = 32,
    parameter int DATA_SIZE      = 32,
    parameter int REG_COUNT_SIZE = 4,
    parameter int READ_LATENCY   = 1,
    parameter logic [DATA_SIZE-1:0] ID_VALUE = 32'hA5A1_0001
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    avslave_chipselect,
    input  logic                    avslave_read,
    input  logic                    avslave_write,
    input  logic [ADDRESS_SIZE-1:0] avslave_address,
    input  logic [DATA_SIZE-1:0]    avslave_writedata,
    output logic [DATA_SIZE-1:0]    avslave_readdata,
    output logic                    avslave_readdatavalid,
    output logic                    irq
);

    localparam int NREG = 2 ** REG_COUNT_SIZE;
    localparam logic [ADDRESS_SIZE:0] NREG_A = (ADDRESS_SIZE + 1)'(NREG);
    localparam logic [31:0] BAD32 = 32'hDEAD_BEEF;
    localparam logic [DATA_SIZE+31:0] BAD_EXT = {{DATA_SIZE{1'b0}}, BAD32};
    localparam logic [DATA_SIZE-1:0] BAD = BAD_EXT[DATA_SIZE-1:0];

    logic [2:0]           status_q, status_d;
    logic [DATA_SIZE-1:0] ctrl_q, ctrl_d;
    logic [DATA_SIZE-1:0] wcount_q, wcount_d;
    logic [DATA_SIZE-1:0] wcount_inc;
    logic                 wrap;
    logic [DATA_SIZE-1:0] gp_q [NREG-1:4];
    logic                 irq_q;

    logic [READ_LATENCY-1:0] vld_q;
    logic [DATA_SIZE-1:0]    dat_q [READ_LATENCY];

    logic                      rd, wr, oor, illegal;
    logic                      rd_ok, wr_ok, cnt_wr, gp_wr;
    logic [REG_COUNT_SIZE-1:0] idx;
    logic [DATA_SIZE-1:0]      rdata;

    assign oor     = {1'b0, avslave_address} >= NREG_A;
    assign idx     = avslave_address[REG_COUNT_SIZE-1:0];
    assign rd      = avslave_chipselect & avslave_read;
    assign wr      = avslave_chipselect & avslave_write;
    assign illegal = (rd | wr) & (oor | (rd & wr));
    assign wr_ok   = wr & ~oor;
    assign rd_ok   = rd & ~wr;
    assign cnt_wr  = wr_ok & (idx != '0);
    assign gp_wr   = wr_ok & (idx >= REG_COUNT_SIZE'(4));

    assign {wrap, wcount_inc} = {1'b0, wcount_q} + (DATA_SIZE + 1)'(1);

    always_comb begin
        rdata = '0;
        if (oor) begin
            rdata = BAD;
        end else if (idx == REG_COUNT_SIZE'(0)) begin
            rdata = ID_VALUE;
        end else if (idx == REG_COUNT_SIZE'(1)) begin
            rdata = DATA_SIZE'(status_q);
        end else if (idx == REG_COUNT_SIZE'(2)) begin
            rdata = ctrl_q;
        end else if (idx == REG_COUNT_SIZE'(3)) begin
            rdata = wcount_q;
        end else begin
            rdata = gp_q[idx];
        end
    end

    // Clear is applied before the sets so a same-cycle event is never lost
    always_comb begin
        status_d = status_q;
        if (wr_ok && idx == REG_COUNT_SIZE'(1))
            status_d = status_q & ~avslave_writedata[2:0];
        if (gp_wr)
            status_d[0] = 1'b1;
        if (illegal)
            status_d[1] = 1'b1;
        if (cnt_wr && wrap)
            status_d[2] = 1'b1;
    end

    always_comb begin
        ctrl_d   = ctrl_q;
        wcount_d = wcount_q;
        if (wr_ok && idx == REG_COUNT_SIZE'(2))
            ctrl_d = avslave_writedata;
        if (cnt_wr)
            wcount_d = wcount_inc;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            status_q <= '0;
            ctrl_q   <= '0;
            wcount_q <= '0;
            irq_q    <= 1'b0;
            for (int i = 4; i < NREG; i++)
                gp_q[i] <= '0;
        end else begin
            status_q <= status_d;
            ctrl_q   <= ctrl_d;
            wcount_q <= wcount_d;
            irq_q    <= |(status_q & ctrl_q[2:0]);
            if (gp_wr)
                gp_q[idx] <= avslave_writedata;
        end
    end

    // Data travels zeroed when invalid, so readdata is 0 without valid
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++)
                dat_q[i] <= '0;
        end else begin
            vld_q[0] <= rd_ok;
            dat_q[0] <= rd_ok ? rdata : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign avslave_readdata      = dat_q[READ_LATENCY-1];
    assign avslave_readdatavalid = vld_q[READ_LATENCY-1];
    assign irq                   = irq_q;

endmodule

// File: tb/tb_avalon_slave_regbank.sv
// Directed bench for avalon_slave_regbank: latency-1 instance for register
// behaviour and a latency-3 instance for the read pipeline.
module tb_avalon_slave_regbank;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cs = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata1, rdata3;
    logic        rvld1, rvld3;
    logic        irq1, irq3;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    avalon_slave_regbank #(.READ_LATENCY(1)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .avslave_chipselect    (cs),
        .avslave_read          (rd),
        .avslave_write         (wr),
        .avslave_address       (addr),
        .avslave_writedata     (wdata),
        .avslave_readdata      (rdata1),
        .avslave_readdatavalid (rvld1),
        .irq                   (irq1)
    );

    avalon_slave_regbank #(.READ_LATENCY(3)) dut3 (
        .clk                   (clk),
        .reset                 (reset),
        .avslave_chipselect    (cs),
        .avslave_read          (rd),
        .avslave_write         (wr),
        .avslave_address       (addr),
        .avslave_writedata     (wdata),
        .avslave_readdata      (rdata3),
        .avslave_readdatavalid (rvld3),
        .irq                   (irq3)
    );

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        cs = 1'b0;
        rd = 1'b0;
        wr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d);
        cs    = 1'b1;
        rd    = r;
        wr    = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        cs = 1'b0;
        rd = 1'b0;
        wr = 1'b0;
    endtask

    task automatic wr1(input logic [31:0] a, input logic [31:0] d);
        bus(1'b0, 1'b1, a, d);
    endtask

    task automatic rd1(input string tag, input logic [31:0] a,
                       input logic [31:0] exp);
        bus(1'b1, 1'b0, a, 32'h0);
        check_eq({tag, "_vld"}, 32'(rvld1), 32'd1);
        check_eq(tag, rdata1, exp);
    endtask

    task automatic pipe_run(input bit do_reset, input string tag);
        for (int c = 0; c < 10; c++) begin
            cs = (c < 4);
            rd = (c < 4);
            wr = 1'b0;
            addr = 32'(4 + c);
            reset = !(do_reset && c == 4);
            @(posedge clk);
            #1;
            if (c >= 2 && c <= 5 && !(do_reset && c >= 4)) begin
                check_eq($sformatf("%s_vld%0d", tag, c), 32'(rvld3), 32'd1);
                check_eq($sformatf("%s_dat%0d", tag, c), rdata3,
                         32'h100 + 32'(c + 2));
            end else begin
                check_eq($sformatf("%s_novld%0d", tag, c), 32'(rvld3), 32'd0);
                check_eq($sformatf("%s_zero%0d", tag, c), rdata3, 32'd0);
            end
        end
        reset = 1'b1;
        cs = 1'b0;
        rd = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_vld", 32'(rvld1), 32'd0);
        check_eq("rst_data", rdata1, 32'd0);
        check_eq("rst_irq", 32'(irq1), 32'd0);
        check_eq("rst_vld3", 32'(rvld3), 32'd0);
        reset = 1'b1;
        idle();

        rd1("id", 32'd0, 32'hA5A1_0001);
        check_eq("irq0", 32'(irq1), 32'd0);
        wr1(32'd0, 32'hFFFF_FFFF);
        rd1("id_ro", 32'd0, 32'hA5A1_0001);

        wr1(32'd5, 32'h1234_5678);
        rd1("gp5", 32'd5, 32'h1234_5678);
        rd1("wcnt1", 32'd3, 32'd1);
        rd1("stat1", 32'd1, 32'h1);

        wr1(32'd1, 32'h7);
        wr1(32'd2, 32'h1);
        idle();
        check_eq("irq_off", 32'(irq1), 32'd0);
        wr1(32'd6, 32'h0000_CAFE);
        check_eq("irq_lag", 32'(irq1), 32'd0);
        idle();
        check_eq("irq_on", 32'(irq1), 32'd1);
        wr1(32'd1, 32'h1);
        check_eq("irq_hold", 32'(irq1), 32'd1);
        idle();
        check_eq("irq_clr", 32'(irq1), 32'd0);
        rd1("stat_clr", 32'd1, 32'h0);
        rd1("ctrl", 32'd2, 32'h1);

        rd1("oor", 32'd20, 32'hDEAD_BEEF);
        rd1("stat_ill", 32'd1, 32'h2);
        bus(1'b1, 1'b1, 32'd7, 32'h0000_0077);
        check_eq("rw_novld", 32'(rvld1), 32'd0);
        rd1("rw_wr", 32'd7, 32'h0000_0077);
        rd1("wcnt6", 32'd3, 32'd6);
        wr1(32'd20, 32'h5555_5555);
        rd1("wcnt_oor", 32'd3, 32'd6);
        cs = 1'b0;
        rd = 1'b0;
        wr = 1'b1;
        addr = 32'd7;
        wdata = 32'h9999_9999;
        @(posedge clk);
        #1;
        wr = 1'b0;
        check_eq("nocs_vld", 32'(rvld1), 32'd0);
        rd1("nocs", 32'd7, 32'h0000_0077);

        wr1(32'd1, 32'h7);
        force dut.wcount_q = 32'hFFFF_FFFF;
        #1;
        release dut.wcount_q;
        wr1(32'd4, 32'h0000_0044);
        rd1("wrap_cnt", 32'd3, 32'd0);
        rd1("wrap_stat", 32'd1, 32'h5);

        for (int i = 4; i < 8; i++)
            wr1(32'(i), 32'h100 + 32'(i));
        idle();
        idle();
        idle();
        pipe_run(1'b0, "p3");
        idle();
        idle();
        idle();
        for (int i = 4; i < 8; i++)
            wr1(32'(i), 32'h100 + 32'(i));
        idle();
        idle();
        idle();
        pipe_run(1'b1, "p3rst");
        check_eq("post_rst_irq", 32'(irq1), 32'd0);
        rd1("post_rst_gp", 32'd5, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
